player_motion_ctrl: RTL and testbench

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

---
 rtl/player_motion_ctrl.sv | 162 ++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// Player sprite motion: joystick-driven horizontal walk with clamping plus a GROUND/RISE/FALL jump FSM.
// Optional PLAYER_JUMP_BUFFER_EN: a press while falling re-launches the jump on the landing tick.
module player_motion_ctrl #(
    parameter int unsigned IMG_W     = 160,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned GROUND_Y  = 360,
    parameter int unsigned JUMP_H    = 30,
    parameter int unsigned STEP_X    = 3,
    parameter int unsigned RISE_STEP = 4,
    parameter int unsigned FALL_STEP = 5,
    parameter int unsigned DEAD_LO   = 400,
    parameter int unsigned DEAD_HI   = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [9:0] jstk_x,
    input  logic       jump_btn,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] mstate,
    output logic       on_ground,
    output logic       jump_start,
    output logic       landed
);

    localparam int unsigned XW = 10;
    localparam int unsigned CW = 11;

    localparam logic [CW-1:0] X_MAX_C     = CW'(SCREEN_W - IMG_W);
    localparam logic [CW-1:0] STEP_X_C    = CW'(STEP_X);
    localparam logic [CW-1:0] GROUND_C    = CW'(GROUND_Y);
    localparam logic [CW-1:0] APEX_C      = CW'(GROUND_Y - JUMP_H);
    localparam logic [CW-1:0] RISE_LIM_C  = CW'(GROUND_Y - JUMP_H + RISE_STEP);
    localparam logic [CW-1:0] RISE_STEP_C = CW'(RISE_STEP);
    localparam logic [CW-1:0] FALL_STEP_C = CW'(FALL_STEP);
    localparam logic [XW-1:0] DEAD_LO_C   = XW'(DEAD_LO);
    localparam logic [XW-1:0] DEAD_HI_C   = XW'(DEAD_HI);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } mstate_e;

    mstate_e       state_q, state_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [XW-1:0] pos_y_q, pos_y_d;
    logic          btn_q, btn_d;
    logic          on_ground_q, on_ground_d;
    logic          jump_start_q, jump_start_d;
    logic          landed_q, landed_d;
    logic          press;
    logic [CW-1:0] x_ext, y_ext;
`ifdef PLAYER_JUMP_BUFFER_EN
    logic          buf_q, buf_d;
`endif

    // State register; reset may hit mid-jump and snaps straight back to the ground.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= GROUND;
            pos_x_q      <= '0;
            pos_y_q      <= XW'(GROUND_Y);
            btn_q        <= 1'b0;
            on_ground_q  <= 1'b1;
            jump_start_q <= 1'b0;
            landed_q     <= 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
            buf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            btn_q        <= btn_d;
            on_ground_q  <= on_ground_d;
            jump_start_q <= jump_start_d;
            landed_q     <= landed_d;
`ifdef PLAYER_JUMP_BUFFER_EN
            buf_q        <= buf_d;
`endif
        end
    end

    // Next-state and motion; everything holds except on tick, pulses self-clear.
    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        btn_d        = btn_q;
        jump_start_d = 1'b0;
        landed_d     = 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
        buf_d        = buf_q;
`endif
        press        = jump_btn & ~btn_q;
        x_ext        = {1'b0, pos_x_q};
        y_ext        = {1'b0, pos_y_q};

        if (tick) begin
            btn_d = jump_btn;

            // Extended width keeps both clamps from wrapping.
            if (jstk_x < DEAD_LO_C) begin
                pos_x_d = (x_ext < STEP_X_C) ? '0 : XW'(x_ext - STEP_X_C);
            end else if (jstk_x > DEAD_HI_C) begin
                pos_x_d = ((x_ext + STEP_X_C) > X_MAX_C) ? XW'(X_MAX_C) : XW'(x_ext + STEP_X_C);
            end

            case (state_q)
                GROUND: begin
                    if (press) begin
                        state_d      = RISE;
                        jump_start_d = 1'b1;
                    end
                end
                RISE: begin
                    if (y_ext <= RISE_LIM_C) begin
                        pos_y_d = XW'(APEX_C);
                        state_d = FALL;
                    end else begin
                        pos_y_d = XW'(y_ext - RISE_STEP_C);
                    end
                end
                FALL: begin
`ifdef PLAYER_JUMP_BUFFER_EN
                    buf_d = buf_q | press;
`endif
                    if ((y_ext + FALL_STEP_C) >= GROUND_C) begin
                        pos_y_d  = XW'(GROUND_C);
                        state_d  = GROUND;
                        landed_d = 1'b1;
`ifdef PLAYER_JUMP_BUFFER_EN
                        if (buf_q | press) begin
                            state_d      = RISE;
                            jump_start_d = 1'b1;
                            buf_d        = 1'b0;
                        end
`endif
                    end else begin
                        pos_y_d = XW'(y_ext + FALL_STEP_C);
                    end
                end
                default: begin
                    state_d = GROUND;
                    pos_y_d = XW'(GROUND_C);
                end
            endcase
        end

        on_ground_d = (state_d == GROUND);
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign mstate     = state_q;
    assign on_ground  = on_ground_q;
    assign jump_start = jump_start_q;
    assign landed     = landed_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: vector table plus jump, reset, buffering and idle sequences.
module tb_player_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [9:0] jstk_x;
    logic       jump_btn;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] mstate;
    logic       on_ground;
    logic       jump_start;
    logic       landed;

    int errors = 0;
    int checks = 0;

    player_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .jstk_x     (jstk_x),
        .jump_btn   (jump_btn),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .mstate     (mstate),
        .on_ground  (on_ground),
        .jump_start (jump_start),
        .landed     (landed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] jx;
        logic       b;
        int         ex;
        int         ey;
        int         es;
        int         ejs;
        int         eld;
    } vec_t;

    vec_t vec[16];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int ex, input int ey, input int es,
                           input int ejs, input int eld);
        chk({nm, ".pos_x"}, int'(pos_x), ex);
        chk({nm, ".pos_y"}, int'(pos_y), ey);
        chk({nm, ".mstate"}, int'(mstate), es);
        chk({nm, ".on_ground"}, int'(on_ground), (es == 0) ? 1 : 0);
        chk({nm, ".jump_start"}, int'(jump_start), ejs);
        chk({nm, ".landed"}, int'(landed), eld);
    endtask

    // One tick strobe; returns at the following negedge with outputs updated.
    task automatic do_tick(input logic [9:0] x, input logic b);
        @(negedge clk);
        jstk_x   = x;
        jump_btn = b;
        tick     = 1'b1;
        @(negedge clk);
        tick     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int ya[14];
        int bad;

        rst = 1'b0; tick = 1'b0; jstk_x = 10'd500; jump_btn = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 360, 0, 0, 0);
        rst = 1'b1;

        // Left clamp at zero, dead-zone edges, then a press with air control.
        for (int i = 0; i < 5; i++) vec[i] = '{10'd0, 1'b0, 0, 360, 0, 0, 0};
        vec[5]  = '{10'd1023, 1'b0, 3, 360, 0, 0, 0};
        vec[6]  = '{10'd1023, 1'b0, 6, 360, 0, 0, 0};
        vec[7]  = '{10'd500,  1'b0, 6, 360, 0, 0, 0};
        vec[8]  = '{10'd400,  1'b0, 6, 360, 0, 0, 0};
        vec[9]  = '{10'd600,  1'b0, 6, 360, 0, 0, 0};
        vec[10] = '{10'd399,  1'b0, 3, 360, 0, 0, 0};
        vec[11] = '{10'd601,  1'b0, 6, 360, 0, 0, 0};
        vec[12] = '{10'd1023, 1'b1, 9, 360, 1, 1, 0};
        vec[13] = '{10'd500,  1'b1, 9, 356, 1, 0, 0};
        vec[14] = '{10'd0,    1'b0, 6, 352, 1, 0, 0};
        vec[15] = '{10'd0,    1'b1, 3, 348, 1, 0, 0};
        for (int i = 0; i < 16; i++) begin
            do_tick(vec[i].jx, vec[i].b);
            chk_all($sformatf("vec%0d", i), vec[i].ex, vec[i].ey, vec[i].es, vec[i].ejs, vec[i].eld);
        end

        // Full jump with the button held throughout.
        do_reset();
        chk_all("reset2", 0, 360, 0, 0, 0);
        do_tick(10'd500, 1'b1);
        chk_all("jump_press", 0, 360, 1, 1, 0);
        ya = '{356, 352, 348, 344, 340, 336, 332, 330, 335, 340, 345, 350, 355, 360};
        for (int i = 0; i < 14; i++) begin
            do_tick(10'd500, 1'b1);
            chk_all($sformatf("jump%0d", i), 0, ya[i], (i < 7) ? 1 : ((i < 13) ? 2 : 0),
                    0, (i == 13) ? 1 : 0);
        end
        @(negedge clk);
        chk("landed_clear", int'(landed), 0);
        for (int i = 0; i < 3; i++) begin
            do_tick(10'd500, 1'b1);
            chk_all($sformatf("held%0d", i), 0, 360, 0, 0, 0);
        end

        // Reset mid-rise, with the button held through reset.
        do_reset();
        do_tick(10'd1023, 1'b1);
        for (int i = 0; i < 4; i++) do_tick(10'd1023, 1'b1);
        chk_all("pre_rst", 15, 344, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("mid_rst", 0, 360, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        do_tick(10'd500, 1'b1);
        chk_all("rst_held_press", 0, 360, 1, 1, 0);

        // Press during FALL.
        for (int i = 0; i < 8; i++) do_tick(10'd500, 1'b1);
        chk_all("apex", 0, 330, 2, 0, 0);
        do_tick(10'd500, 1'b0);
        do_tick(10'd500, 1'b1);
        chk_all("fall_press", 0, 340, 2, 0, 0);
        for (int i = 0; i < 3; i++) do_tick(10'd500, 1'b0);
        chk_all("pre_land", 0, 355, 2, 0, 0);
        do_tick(10'd500, 1'b0);
`ifdef PLAYER_JUMP_BUFFER_EN
        chk_all("buf_land", 0, 360, 1, 1, 1);
        do_tick(10'd500, 1'b0);
        chk_all("buf_rise", 0, 356, 1, 0, 0);
`else
        chk_all("land_ground", 0, 360, 0, 0, 1);
        do_tick(10'd500, 1'b0);
        chk_all("stay_ground", 0, 360, 0, 0, 0);
`endif

        // No tick for 1000 clocks: nothing moves.
        do_reset();
        for (int i = 0; i < 4; i++) do_tick(10'd1023, 1'b0);
        chk_all("pre_idle", 12, 360, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            jstk_x   = 10'($urandom_range(1023, 0));
            jump_btn = 1'($urandom_range(1, 0));
            if (pos_x != 10'd12 || pos_y != 10'd360 || mstate != 2'd0 ||
                on_ground != 1'b1 || jump_start != 1'b0 || landed != 1'b0) bad++;
        end
        chk("idle_changes", bad, 0);
        chk_all("post_idle", 12, 360, 0, 0, 0);

        // Right clamp at SCREEN_W-IMG_W.
        for (int i = 0; i < 200; i++) do_tick(10'd1023, 1'b0);
        chk_all("right_clamp", 480, 360, 0, 0, 0);
        do_tick(10'd500, 1'b0);
        chk("right_hold", int'(pos_x), 480);
        do_tick(10'd1023, 1'b0);
        chk("right_stay", int'(pos_x), 480);
        do_tick(10'd0, 1'b0);
        chk("right_back", int'(pos_x), 477);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
